i2s_tx_serializer: RTL

Parametrised stereo audio serializer feeding the external DAC from the sample datapath. It accepts left/right sample pairs over a valid/ready handshake into a small FIFO, generates BCK by dividing the system clock, and shifts samples out in I2S, left-justified or right-justified format with configurable slot width. Underruns are flagged, and a LATCH strobe is available for latch-style DACs.

---
 rtl/i2s_tx_serializer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_serializer
// Brief    : Stereo audio serializer. It buffers L/R pairs in a small FIFO,
//            divides CLK down to BCK and shifts samples out in I2S,
//            left-justified or right-justified format with an underrun flag.
// Options  : define I2S_TX_LATCH_EN to generate the end-of-frame LATCH strobe.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int BCK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          ENABLE,
  input  logic [1:0]                    MODE,
  input  logic [DATA_WIDTH-1:0]         DATA_L,
  input  logic [DATA_WIDTH-1:0]         DATA_R,
  input  logic                          VALID,
  output logic                          READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          BCK,
  output logic                          WS,
  output logic                          DATAO,
  output logic                          LATCH,
  output logic                          UNDERRUN
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_BIT_W = $clog2(SLOT_WIDTH);
  localparam int c_DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(SLOT_WIDTH - 1);
  localparam logic [c_DIV_W-1:0] c_LAST_DIV = c_DIV_W'(BCK_DIV - 1);
  localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_PTR_W:0]        r_level;
  logic                    w_push;
  logic                    w_pop;

  logic [c_DIV_W-1:0]      r_div_cnt;
  logic                    r_bck;
  logic                    w_wrap;
  logic                    w_fall;

  logic [c_BIT_W-1:0]      r_bit;
  logic                    r_slot;
  logic [c_BIT_W-1:0]      w_bit_next;
  logic                    w_slot_next;
  logic [1:0]              r_mode;
  logic [DATA_WIDTH-1:0]   r_left;
  logic [DATA_WIDTH-1:0]   r_right;
  logic [1:0]              w_mode_next;
  logic [DATA_WIDTH-1:0]   w_left_next;
  logic [DATA_WIDTH-1:0]   w_right_next;
  logic                    w_bit_val;

  logic                    w_start;
  logic                    w_frame_end;
  logic                    w_go_idle;
  logic                    w_frame_start;
  logic                    w_event;

  logic                    r_ws;
  logic                    r_datao;
  logic                    r_underrun;

  // Serial bit for slot position b of a sample in the given format; 0 outside the sample
  function automatic logic f_bit(input logic [1:0] mode, input logic [c_BIT_W-1:0] b,
                                 input logic [DATA_WIDTH-1:0] d);
    int                    idx;
    logic [DATA_WIDTH-1:0] sh;
    sh    = '0;
    f_bit = 1'b0;
    case (mode)
      2'd1:    idx = DATA_WIDTH - 1 - int'(b);
      2'd2:    idx = SLOT_WIDTH - 1 - int'(b);
      default: idx = DATA_WIDTH - int'(b);
    endcase
    if (idx >= 0 && idx < DATA_WIDTH) begin
      sh    = d >> idx;
      f_bit = sh[0];
    end
  endfunction

  assign READY      = (r_level != c_FULL);
  assign FIFO_LEVEL = r_level;
  assign w_push     = VALID && READY;
  assign w_pop      = w_frame_start && (r_level != '0);

  assign w_wrap        = (r_div_cnt == c_LAST_DIV);
  assign w_fall        = (r_state != S_IDLE) && w_wrap && r_bck;
  assign w_start       = (r_state == S_IDLE) && ENABLE;
  assign w_frame_end   = r_slot && (r_bit == c_LAST_BIT);
  assign w_go_idle     = w_fall && w_frame_end && !ENABLE;
  assign w_frame_start = w_start || (w_fall && w_frame_end && ENABLE);
  assign w_event       = w_start || w_fall;

  assign BCK      = r_bck;
  assign WS       = r_ws;
  assign DATAO    = r_datao;
  assign UNDERRUN = r_underrun;

  // FIFO storage; contents need no reset because the level gates every read
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {DATA_L, DATA_R};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: a stop only takes effect at the end of a frame
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (ENABLE) w_state_next = S_RUN;
      S_RUN:   if (w_go_idle) w_state_next = S_IDLE;
               else if (!ENABLE) w_state_next = S_STOP;
      S_STOP:  if (w_go_idle) w_state_next = S_IDLE;
               else if (ENABLE) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  // BCK divider; held low and phase-reset while idle so the first rise is BCK_DIV cycles after start
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_bck     <= ~r_bck;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Next slot position and frame data, including the pop at each frame start
  always_comb begin
    w_bit_next   = r_bit;
    w_slot_next  = r_slot;
    w_mode_next  = r_mode;
    w_left_next  = r_left;
    w_right_next = r_right;
    if (w_start) begin
      w_bit_next  = '0;
      w_slot_next = 1'b0;
    end else if (w_fall) begin
      if (r_bit == c_LAST_BIT) begin
        w_bit_next  = '0;
        w_slot_next = ~r_slot;
      end else begin
        w_bit_next = r_bit + 1'b1;
      end
    end
    if (w_frame_start) begin
      w_mode_next = MODE;
      if (r_level != '0) {w_left_next, w_right_next} = r_mem[r_rd_ptr];
      else               {w_left_next, w_right_next} = '0;
    end
    w_bit_val = f_bit(w_mode_next, w_bit_next, w_slot_next ? w_right_next : w_left_next);
  end

  // Frame-wide mode and sample registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mode  <= 2'd0;
      r_left  <= '0;
      r_right <= '0;
    end else begin
      r_mode  <= w_mode_next;
      r_left  <= w_left_next;
      r_right <= w_right_next;
    end
  end

  // Slot position and serial outputs, updated on start and fall events only
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bit   <= '0;
      r_slot  <= 1'b0;
      r_ws    <= 1'b0;
      r_datao <= 1'b0;
    end else if (w_go_idle) begin
      r_bit   <= '0;
      r_slot  <= 1'b0;
      r_ws    <= 1'b0;
      r_datao <= 1'b0;
    end else if (w_event) begin
      r_bit   <= w_bit_next;
      r_slot  <= w_slot_next;
      r_ws    <= w_slot_next;
      r_datao <= w_bit_val;
    end
  end

  // Sticky underrun, set by a frame start on an empty FIFO, cleared by disabling
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                              r_underrun <= 1'b0;
    else if (!ENABLE)                        r_underrun <= 1'b0;
    else if (w_frame_start && r_level == '0) r_underrun <= 1'b1;
  end

`ifdef I2S_TX_LATCH_EN
  logic r_latch;

  // LATCH covers the BCK period of the last bit of the right slot
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         r_latch <= 1'b0;
    else if (w_go_idle) r_latch <= 1'b0;
    else if (w_event)   r_latch <= w_slot_next && (w_bit_next == c_LAST_BIT);
  end

  assign LATCH = r_latch;
`else
  assign LATCH = 1'b0;
`endif

endmodule
`default_nettype wire
